mod3_serial_tx: RTL and testbench



---
 rtl/mod3_pkg.sv | 41 ++++
 rtl/mod3_rem_tracker.sv | 24 ++
 rtl/mod3_serial_tx.sv | 97 +++++++++
 tb/tb_mod3_serial_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod3_pkg.sv
// rtl/mod3_pkg.sv - shared types and helpers for the serial divisible-by-3 link
// Remainder encoding is shared with the receive-side checker.
package mod3_pkg;

   typedef enum logic [1:0] {
      REM_0 = 2'd0,
      REM_1 = 2'd1,
      REM_2 = 2'd2
   } rem_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CHK1 = 2'd2,
      CHK0 = 2'd3
   } tx_state_t;

   // Remainder after appending bit b to a stream with remainder rem: (2*rem + b) mod 3.
   function automatic rem_t rem_next(input rem_t rem, input logic b);
      rem_t r;
      case (rem)
         REM_0:   r = b ? REM_1 : REM_0;
         REM_1:   r = b ? REM_0 : REM_2;
         REM_2:   r = b ? REM_2 : REM_1;
         default: r = REM_0;
      endcase
      return r;
   endfunction

   // Check field c = (3 - r) mod 3, so that (4*payload + c) is a multiple of 3.
   function automatic logic [1:0] chk_bits(input rem_t rem);
      logic [1:0] c;
      case (rem)
         REM_1:   c = 2'b10;
         REM_2:   c = 2'b01;
         default: c = 2'b00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mod3_rem_tracker.sv
// rtl/mod3_rem_tracker.sv - registered running mod-3 remainder of a bit stream
// clr has priority so a frame boundary and a new frame's first bit never mix.
module mod3_rem_tracker
   import mod3_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   input  logic din,
   output rem_t rem
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem <= REM_0;
      end else if (clr) begin
         rem <= REM_0;
      end else if (en) begin
         rem <= rem_next(rem, din);
      end
   end

endmodule

// File: rtl/mod3_serial_tx.sv
// rtl/mod3_serial_tx.sv - serializes a payload MSB-first and appends a 2-bit mod-3 check field
// The full DATA_W+2 bit frame, read as an unsigned number, is divisible by 3.
module mod3_serial_tx
   import mod3_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              bit_o,
   output logic              bit_valid_o,
   output logic              last_o,
   input  logic              out_ready_i
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   tx_state_t         state, state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   rem_t              rem;
   logic [1:0]        chk;
   logic              consume;
   logic              accept;
   logic              data_last;

   assign chk       = chk_bits(rem);
   // Derived from state rather than bit_valid_o to keep the output decode loop-free.
   assign consume   = (state != IDLE) & out_ready_i;
   assign ready_o   = (state == IDLE) | ((state == CHK0) & out_ready_i);
   assign accept    = valid_i & ready_o;
   assign data_last = (cnt == CNT_LAST);

   mod3_rem_tracker u_rem (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (consume & (state == DATA)),
      .clr     (consume & (state == CHK0)),
      .din     (shreg[DATA_W-1]),
      .rem     (rem)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (accept) begin
         shreg <= data_i;
         cnt   <= '0;
      end else if (consume && (state == DATA)) begin
         shreg <= {shreg[DATA_W-2:0], 1'b0};
         cnt   <= data_last ? '0 : cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_o       = 1'b0;
      bit_valid_o = 1'b0;
      last_o      = 1'b0;
      case (state)
         IDLE: begin
            if (valid_i) state_nxt = DATA;
         end
         DATA: begin
            bit_valid_o = 1'b1;
            bit_o       = shreg[DATA_W-1];
            if (consume && data_last) state_nxt = CHK1;
         end
         CHK1: begin
            bit_valid_o = 1'b1;
            bit_o       = chk[1];
            if (consume) state_nxt = CHK0;
         end
         CHK0: begin
            bit_valid_o = 1'b1;
            bit_o       = chk[0];
            last_o      = 1'b1;
            if (consume) state_nxt = accept ? DATA : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mod3_serial_tx.sv
// tb/tb_mod3_serial_tx.sv - self-checking bench for mod3_serial_tx
module tb_mod3_serial_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic [7:0] data_i;
   logic       valid_i, ready_o, bit_o, bit_valid_o, last_o, out_ready_i;

   logic [1:0]  d2;
   logic        v2, r2, b2, bv2, l2;
   logic [31:0] d32;
   logic        v32, r32, b32, bv32, l32;
   logic        one_w;

   mod3_serial_tx #(.DATA_W(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .bit_o(bit_o), .bit_valid_o(bit_valid_o), .last_o(last_o), .out_ready_i(out_ready_i)
   );

   mod3_serial_tx #(.DATA_W(2)) u_w2 (
      .clk(clk), .reset_n(reset_n), .data_i(d2), .valid_i(v2), .ready_o(r2),
      .bit_o(b2), .bit_valid_o(bv2), .last_o(l2), .out_ready_i(one_w)
   );

   mod3_serial_tx #(.DATA_W(32)) u_w32 (
      .clk(clk), .reset_n(reset_n), .data_i(d32), .valid_i(v32), .ready_o(r32),
      .bit_o(b32), .bit_valid_o(bv32), .last_o(l32), .out_ready_i(one_w)
   );

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   vec_t       tbl[11];
   logic [9:0] sb[$];
   int         n_vec = 0;
   int         n_miss = 0;
   int         mode = 0;
   int         phase = 0;

   logic [9:0] cur, e;
   int         mon_len, crem, frames_done, run, last_run;
   logic       prev_stall, prev_bit, prev_last;

   longint unsigned acc2, acc32;
   int              len2, len32, done2, done32;
   logic [1:0]      exp2;
   logic [31:0]     exp32;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] exp_frame(input logic [7:0] d);
      int         c;
      logic [1:0] cc;
      c  = (3 - (int'(d) % 3)) % 3;
      cc = 2'(c);
      return {d, cc};
   endfunction

   // Downstream readiness: always ready, fixed 1,0,0 pattern, or random.
   initial begin
      out_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: out_ready_i = 1'b1;
            1: begin
               out_ready_i = (phase == 0);
               phase = (phase + 1) % 3;
            end
            default: out_ready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Scoreboard monitor with a loopback mod-3 checker on the serial stream.
   initial begin
      frames_done = 0;
      last_run    = 0;
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         cur = '0; mon_len = 0; crem = 0; prev_stall = 1'b0; run = 0;
      end else begin
         if (prev_stall) begin
            check("stall_bit", bit_o, prev_bit);
            check("stall_last", last_o, prev_last);
            check("stall_valid", bit_valid_o, 1'b1);
         end
         if (bit_valid_o) begin
            run++;
            check("ready_in_frame", ready_o, out_ready_i && (mon_len == 9));
            if (out_ready_i) begin
               cur = {cur[8:0], bit_o};
               mon_len++;
               crem = (2 * crem + int'(bit_o)) % 3;
               check("last_pos", last_o, mon_len == 10);
               if (last_o) begin
                  check("frame_len", mon_len, 10);
                  check("chk_rem", crem, 0);
                  if (sb.size() == 0) begin
                     n_vec++; n_miss++;
                     $display("FAIL sb_underflow: got frame %0h, expected none pending", cur);
                  end else begin
                     e = sb.pop_front();
                     check("frame", cur, e);
                  end
                  frames_done++;
                  cur = '0; mon_len = 0; crem = 0;
               end
            end
         end else begin
            if (run > 0) last_run = run;
            run = 0;
            check("idle_ready", ready_o, 1'b1);
         end
         prev_stall = bit_valid_o && !out_ready_i;
         prev_bit   = bit_o;
         prev_last  = last_o;
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         acc2 = 0; len2 = 0; acc32 = 0; len32 = 0;
      end else begin
         if (bv2) begin
            acc2 = (acc2 << 1) | longint'(b2);
            len2++;
            if (l2) begin
               check("w2_len", len2, 4);
               check("w2_div3", acc2 % 3, 0);
               check("w2_payload", acc2 >> 2, exp2);
               done2++; acc2 = 0; len2 = 0;
            end
         end
         if (bv32) begin
            acc32 = (acc32 << 1) | longint'(b32);
            len32++;
            if (l32) begin
               check("w32_len", len32, 34);
               check("w32_div3", acc32 % 3, 0);
               check("w32_payload", acc32 >> 2, exp32);
               done32++; acc32 = 0; len32 = 0;
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [7:0] d, input logic [9:0] ef);
      int t;
      data_i  = d;
      valid_i = 1'b1;
      sb.push_back(ef);
      t = 0;
      @(negedge clk);
      while (!ready_o && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("accept_timeout", t < 200, 1'b1);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      check("lat_valid", bit_valid_o, 1'b1);
      check("lat_msb", bit_o, d[7]);
   endtask

   task automatic wait_frames(input int target);
      int t;
      t = 0;
      while (frames_done < target && t < 2000) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("frame_timeout", frames_done >= target, 1'b1);
   endtask

   task automatic send2(input logic [1:0] d);
      int t, target;
      target = done2 + 1;
      d2 = d; exp2 = d; v2 = 1'b1;
      t = 0;
      @(negedge clk);
      while (!r2 && t < 100) begin @(negedge clk); t++; end
      @(posedge clk);
      #1;
      v2 = 1'b0;
      while (done2 < target && t < 200) begin @(posedge clk); t++; end
      #1;
      check("w2_timeout", done2 >= target, 1'b1);
   endtask

   task automatic send32(input logic [31:0] d);
      int t, target;
      target = done32 + 1;
      d32 = d; exp32 = d; v32 = 1'b1;
      t = 0;
      @(negedge clk);
      while (!r32 && t < 100) begin @(negedge clk); t++; end
      @(posedge clk);
      #1;
      v32 = 1'b0;
      while (done32 < target && t < 200) begin @(posedge clk); t++; end
      #1;
      check("w32_timeout", done32 >= target, 1'b1);
   endtask

   initial begin
      tbl[0]  = '{8'h05, 10'h015};
      tbl[1]  = '{8'h07, 10'h01E};
      tbl[2]  = '{8'hFF, 10'h3FC};
      tbl[3]  = '{8'h06, 10'h018};
      tbl[4]  = '{8'hA5, 10'h294};
      tbl[5]  = '{8'h01, 10'h006};
      tbl[6]  = '{8'h00, 10'h000};
      tbl[7]  = '{8'h80, 10'h201};
      tbl[8]  = '{8'h02, 10'h009};
      tbl[9]  = '{8'hFE, 10'h3F9};
      tbl[10] = '{8'h55, 10'h156};

      reset_n = 1'b0; valid_i = 1'b0; data_i = '0;
      d2 = '0; v2 = 1'b0; d32 = '0; v32 = 1'b0; one_w = 1'b1;
      done2 = 0; done32 = 0; exp2 = '0; exp32 = '0;
      #3;
      check("rst_ready", ready_o, 1'b1);
      check("rst_bit", bit_o, 1'b0);
      check("rst_valid", bit_valid_o, 1'b0);
      check("rst_last", last_o, 1'b0);
      #19 reset_n = 1'b1;
      @(posedge clk); #1;

      // Single frame 0x05 -> 00000101 01
      send(tbl[0].data, tbl[0].frame);
      wait_frames(1);

      // Back-to-back 0x07, 0xFF with no bubble between frames
      send(tbl[1].data, tbl[1].frame);
      send(tbl[2].data, tbl[2].frame);
      wait_frames(3);
      repeat (2) @(posedge clk);
      check("b2b_run", last_run, 20);

      // Stalling downstream 1,0,0,...
      @(posedge clk); #1;
      mode = 1; phase = 0;
      send(tbl[3].data, tbl[3].frame);
      wait_frames(4);
      mode = 0;

      // Reset after the third data bit of 0xA5
      @(posedge clk); #1;
      send(tbl[4].data, tbl[4].frame);
      for (int t = 0; t < 100 && mon_len < 3; t++) begin
         @(posedge clk); #1;
      end
      check("mid_reached", mon_len, 3);
      #1;
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", bit_valid_o, 1'b0);
      check("mid_rst_bit", bit_o, 1'b0);
      check("mid_rst_last", last_o, 1'b0);
      check("mid_rst_ready", ready_o, 1'b1);
      sb.delete();
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk); #1;
      send(tbl[5].data, tbl[5].frame);
      wait_frames(5);

      // Full table under each downstream mode
      for (int i = 0; i < 11; i++) begin
         mode = i % 3;
         send(tbl[i].data, tbl[i].frame);
      end
      wait_frames(16);

      // Random payloads with random stalls
      mode = 2;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         send(d, exp_frame(d));
      end
      wait_frames(32);
      mode = 0;

      // Width sweep: DATA_W=2 and DATA_W=32
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) send2(2'(k));
      send32(32'hFFFF_FFFF);
      send32(32'h0000_0000);
      send32(32'h0000_0001);
      send32(32'h8000_0002);
      for (int k = 0; k < 3; k++) send32($urandom);

      repeat (3) @(posedge clk);
      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
